cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_arbiter_pick.sv | 39 +++
 rtl/cdb_arbiter.sv | 82 ++++++++
 tb/tb_cdb_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: CDB sizing defaults and the rotating-index helper shared by the arbiter files
`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 2
`endif
`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 1
`endif
`ifndef CDB_STARVE_LIMIT
`define CDB_STARVE_LIMIT 3
`endif

package cdb_arbiter_pkg;
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction
endpackage

// File: rtl/cdb_arbiter_pick.sv
// rr_pick: scans mask from ptr_i in rotating order and fills CDB slots from start_i upward
module rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int NUM_GNT = 2
) (
    input  logic [NUM_REQ-1:0]                        mask_i,
    input  logic [$clog2(NUM_REQ)-1:0]                ptr_i,
    input  logic [$clog2(NUM_GNT+1)-1:0]              start_i,
    output logic [NUM_REQ-1:0]                        sel_o,
    output logic [NUM_GNT-1:0][$clog2(NUM_REQ)-1:0]   idx_o,
    output logic [$clog2(NUM_GNT+1)-1:0]              stop_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(NUM_GNT+1);

    logic [NUM_REQ-1:0] rot;

    always_comb begin
        int cnt;
        int r;
        rot = NUM_REQ'({mask_i, mask_i} >> ptr_i);
        sel_o = '0;
        idx_o = '0;
        cnt = int'(start_i);
        r = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (rot[j] && cnt < NUM_GNT) begin
                r = wrap_add(int'(ptr_i), j, NUM_REQ);
                sel_o = sel_o | (NUM_REQ'(1) << r);
                for (int k = 0; k < NUM_GNT; k++)
                    if (cnt == k) idx_o[k] = IW'(r);
                cnt++;
            end
        end
        stop_o = CW'(cnt);
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: zero-latency CDB slot arbiter with aged, high-priority and normal classes over a rotating pointer
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int                NUM_REQ      = `NUM_FU_ALU + `NUM_FU_MULT + `NUM_FU_LOAD,
    parameter int                NUM_GNT      = `N,
    parameter int                STARVE_LIMIT = `CDB_STARVE_LIMIT,
    parameter logic [NUM_REQ-1:0] HI_PRI      = '0
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req,
    input  logic                                      squash,
    output logic [NUM_REQ-1:0]                        grant,
    output logic [NUM_GNT-1:0]                        grant_valid,
    output logic [NUM_GNT-1:0][$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic [NUM_REQ-1:0]                        stall
`ifdef CPU_DEBUG_OUT
    ,output logic [$clog2(NUM_REQ)-1:0]               ptr_debug
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(NUM_GNT+1);
    localparam int AW = $clog2(STARVE_LIMIT+1);

    logic [IW-1:0]              ptr_q, ptr_d;
    logic [NUM_REQ-1:0][AW-1:0] age_q, age_d;
    logic [NUM_REQ-1:0]         aged, hi, lo, sel_a, sel_h, sel_l, denied, rot;
    logic [NUM_GNT-1:0][IW-1:0] idx_a, idx_h, idx_l;
    logic [CW-1:0]              stop_a, stop_h, stop_l;
    logic                       off;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            aged[i] = req[i] && (age_q[i] >= AW'(STARVE_LIMIT));
        hi = req & ~aged & HI_PRI;
        lo = req & ~aged & ~HI_PRI;
    end

    // Each class resumes filling at the slot where the previous class stopped.
    rr_pick #(.NUM_REQ(NUM_REQ), .NUM_GNT(NUM_GNT)) u_aged (
        .mask_i(aged), .ptr_i(ptr_q), .start_i('0), .sel_o(sel_a), .idx_o(idx_a), .stop_o(stop_a));
    rr_pick #(.NUM_REQ(NUM_REQ), .NUM_GNT(NUM_GNT)) u_hi (
        .mask_i(hi), .ptr_i(ptr_q), .start_i(stop_a), .sel_o(sel_h), .idx_o(idx_h), .stop_o(stop_h));
    rr_pick #(.NUM_REQ(NUM_REQ), .NUM_GNT(NUM_GNT)) u_lo (
        .mask_i(lo), .ptr_i(ptr_q), .start_i(stop_h), .sel_o(sel_l), .idx_o(idx_l), .stop_o(stop_l));

    always_comb begin
        off = reset || squash;
        grant = off ? '0 : (sel_a | sel_h | sel_l);
        grant_idx = off ? '0 : (idx_a | idx_h | idx_l);
        for (int k = 0; k < NUM_GNT; k++)
            grant_valid[k] = !off && (k < int'(stop_l));
        stall = reset ? '0 : (req & ~grant);
    end

    always_comb begin
        denied = req & ~grant;
        rot = NUM_REQ'({denied, denied} >> ptr_q);
        ptr_d = ptr_q;
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (rot[j]) ptr_d = IW'(wrap_add(int'(ptr_q), j, NUM_REQ));
        if (squash) ptr_d = '0;
        for (int i = 0; i < NUM_REQ; i++)
            age_d[i] = (squash || !denied[i]) ? '0 :
                       (age_q[i] == AW'(STARVE_LIMIT)) ? age_q[i] : age_q[i] + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            age_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            age_q <= age_d;
        end
    end

`ifdef CPU_DEBUG_OUT
    assign ptr_debug = ptr_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_cdb_arbiter;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             squash = 1'b0;
    logic [4:0]       req = '0;
    logic [4:0]       grant, stall;
    logic [1:0]       grant_valid;
    logic [1:0][2:0]  grant_idx;
    logic             done = 1'b0;
    int               tests = 0;
    int               fails = 0;

    typedef struct {
        logic [4:0] g;
        logic [1:0] gv;
        logic [5:0] idx;
        logic [4:0] st;
    } exp_t;
    exp_t q[$];

    cdb_arbiter #(.NUM_REQ(5), .NUM_GNT(2), .STARVE_LIMIT(3), .HI_PRI(5'b11000)) dut (
        .clock(clk), .reset(reset), .req(req), .squash(squash),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .stall(stall));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [5:0] a, input logic [5:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s at %0t: got %h want %h", n, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("grant", {1'b0, grant}, {1'b0, e.g});
            chk("grant_valid", {4'b0, grant_valid}, {4'b0, e.gv});
            chk("grant_idx", grant_idx, e.idx);
            chk("stall", {1'b0, stall}, {1'b0, e.st});
        end else if (done) begin
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic step(input logic rs, input logic sq, input logic [4:0] r, input logic [4:0] eg,
                        input logic [1:0] egv, input logic [2:0] i1, input logic [2:0] i0,
                        input logic [4:0] es);
        @(posedge clk);
        #1;
        reset = rs;
        squash = sq;
        req = r;
        q.push_back('{eg, egv, {i1, i0}, es});
    endtask

    initial begin
        step(1, 0, 5'b11111, 5'b00000, 2'b00, 0, 0, 5'b00000);
        step(0, 0, 5'b00111, 5'b00011, 2'b11, 1, 0, 5'b00100);
        step(0, 0, 5'b00111, 5'b00101, 2'b11, 0, 2, 5'b00010);
        step(0, 0, 5'b00001, 5'b00001, 2'b01, 0, 0, 5'b00000);
        step(0, 0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000);
        step(1, 0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000);
        step(0, 0, 5'b11001, 5'b11000, 2'b11, 4, 3, 5'b00001);
        step(0, 0, 5'b11001, 5'b11000, 2'b11, 4, 3, 5'b00001);
        step(0, 0, 5'b11001, 5'b11000, 2'b11, 4, 3, 5'b00001);
        step(0, 0, 5'b11001, 5'b01001, 2'b11, 3, 0, 5'b10000);
        step(0, 0, 5'b11001, 5'b11000, 2'b11, 3, 4, 5'b00001);
        step(0, 0, 5'b11001, 5'b11000, 2'b11, 4, 3, 5'b00001);
        step(0, 1, 5'b11001, 5'b00000, 2'b00, 0, 0, 5'b11001);
        step(0, 0, 5'b11001, 5'b11000, 2'b11, 4, 3, 5'b00001);
        step(0, 0, 5'b11001, 5'b11000, 2'b11, 4, 3, 5'b00001);
        step(0, 0, 5'b11001, 5'b11000, 2'b11, 4, 3, 5'b00001);
        step(0, 0, 5'b11001, 5'b01001, 2'b11, 3, 0, 5'b10000);
        step(0, 0, 5'b00111, 5'b00011, 2'b11, 1, 0, 5'b00100);
        step(1, 0, 5'b11111, 5'b00000, 2'b00, 0, 0, 5'b00000);
        step(0, 0, 5'b00111, 5'b00011, 2'b11, 1, 0, 5'b00100);
        step(0, 0, 5'b11111, 5'b11000, 2'b11, 4, 3, 5'b00111);
        @(posedge clk);
        #1;
        req = '0;
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary by %0t want finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
